// File: rtl/microwave_pkg.sv
// Shared constants and types for the microwave keypad entry path.
package microwave_pkg;

  localparam int unsigned KEY_W        = 10;
  localparam int unsigned BCD_W        = 4;
  localparam int unsigned MAX_SEC_TENS = 5;

  // Press-qualification FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } key_state_e;

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad-side and cook-time-side signals of the entry stage.
// The master drives the keypad and control strobes; the slave returns the digits.
interface keypad_entry_if;
  import microwave_pkg::*;

  logic [KEY_W-1:0] keypad;
  logic             entry_enable;
  logic             clear_entry;
  logic [BCD_W-1:0] min_digit;
  logic [BCD_W-1:0] sec_tens_digit;
  logic [BCD_W-1:0] sec_ones_digit;
  logic             key_accepted;
  logic             entry_nonzero;
  logic             time_valid;

  modport master (
    output keypad, entry_enable, clear_entry,
    input  min_digit, sec_tens_digit, sec_ones_digit, key_accepted, entry_nonzero, time_valid
  );

  modport slave (
    input  keypad, entry_enable, clear_entry,
    output min_digit, sec_tens_digit, sec_ones_digit, key_accepted, entry_nonzero, time_valid
  );

endinterface

// File: rtl/onehot_key_decoder.sv
// Combinational keypad qualifier: flags a single pressed key and gives its index.
module onehot_key_decoder
  import microwave_pkg::*;
(
  input  logic [KEY_W-1:0] keypad,
  output logic             single,
  output logic [BCD_W-1:0] code
);

  // Exactly one bit set counts as a key; code is only meaningful when single is high.
  always_comb begin
    single = ($countones(keypad) == 1);
    code   = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (keypad[i]) code = BCD_W'(i);
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry stage: debounces one-hot key presses, accepts each press once
// and shifts the digit into a 3-digit BCD cook-time register.
module keypad_entry
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic           clock,
  input  logic           reset,
  keypad_entry_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntTarget = CNT_W'(DEBOUNCE_CYCLES);

  logic             single;
  logic [BCD_W-1:0] dec_code;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] pattern_q, pattern_d;
  logic [BCD_W-1:0] code_q, code_d;
  logic             accept;
  logic [BCD_W-1:0] accept_code;
  logic             shift;

  logic [BCD_W-1:0] min_q, sec_tens_q, sec_ones_q;
  logic             pulse_q;

  onehot_key_decoder u_decoder (
    .keypad (bus.keypad),
    .single (single),
    .code   (dec_code)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // FSM, debounce counter and captured key registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pattern_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      code_q    <= code_d;
    end
  end

  // Next-state logic: press must be stable for DEBOUNCE_CYCLES samples, then
  // the keypad must read all-zero for DEBOUNCE_CYCLES samples before re-arming.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    code_d      = code_q;
    accept      = 1'b0;
    accept_code = code_q;
    unique case (state_q)
      IDLE: begin
        if (single) begin
          pattern_d = bus.keypad;
          code_d    = dec_code;
          if (DEBOUNCE_CYCLES == 1) begin
            accept      = 1'b1;
            accept_code = dec_code;
            state_d     = WAIT_RELEASE;
            cnt_d       = '0;
          end else begin
            state_d = DEBOUNCE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DEBOUNCE: begin
        if (bus.keypad == pattern_q) begin
          if (cnt_inc == CntTarget) begin
            accept  = 1'b1;
            state_d = WAIT_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        // Any nonzero pattern (including a different key) restarts the release count.
        if (bus.keypad == '0) begin
          if (cnt_inc == CntTarget) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // An accepted press only lands in the digits when enabled and not being cleared.
  assign shift = accept && bus.entry_enable && !bus.clear_entry;

  // BCD shift register and accept pulse; clear wins over a same-edge shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_q      <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      pulse_q <= shift;
      if (bus.clear_entry) begin
        min_q      <= '0;
        sec_tens_q <= '0;
        sec_ones_q <= '0;
      end else if (shift) begin
        min_q      <= sec_tens_q;
        sec_tens_q <= sec_ones_q;
        sec_ones_q <= accept_code;
      end
    end
  end

  assign bus.min_digit      = min_q;
  assign bus.sec_tens_digit = sec_tens_q;
  assign bus.sec_ones_digit = sec_ones_q;
  assign bus.key_accepted   = pulse_q;
  assign bus.entry_nonzero  = |{min_q, sec_tens_q, sec_ones_q};
  assign bus.time_valid     = (sec_tens_q <= BCD_W'(MAX_SEC_TENS));

endmodule
